// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor tile.
// Holds the FSM state enum, default operand width, uio bit positions
// and the fixed uio output-enable pattern.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;

   // uio bit positions
   localparam int UIO_LOAD_A = 0;
   localparam int UIO_LOAD_B = 1;
   localparam int UIO_START  = 2;
   localparam int UIO_BUSY   = 4;
   localparam int UIO_DONE   = 5;
   localparam int UIO_BORROW = 6;
   localparam int UIO_OVF    = 7;

   localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/serial_sub_if.sv
// TinyTapeout user-project pin bundle for the serial subtractor.
// Ports: ui_in (operand bus), uio_in (load_a/load_b/start), uo_out (result),
//        uio_out (busy/done/borrow/ovf), uio_oe (output enables).
interface serial_sub_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   // master drives the tile inputs, slave is the tile itself
   modport master (output ui_in, output uio_in,
                   input  uo_out, input uio_out, input uio_oe);
   modport slave  (input  ui_in, input uio_in,
                   output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/serial_sub_cell.sv
// 1-bit full subtractor with its borrow flop.
// Ports: clk/rst_n/ena, clr (synchronous borrow clear), shift (advance borrow),
//        a0/b0 operand bits, d difference bit, br_next borrow out of this bit.
module serial_sub_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic clr,
   input  logic shift,
   input  logic a0,
   input  logic b0,
   output logic d,
   output logic br_next
);

   logic br;

   assign d       = a0 ^ b0 ^ br;
   // borrow out when a0 < b0, or when bits are equal and a borrow came in
   assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br <= 1'b0;
      end else if (ena) begin
         if (clr)
            br <= 1'b0;
         else if (shift)
            br <= br_next;
      end
   end

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial R = A - B tile, LSB first, WIDTH cycles per result.
// Ports: clk, rst_n (async active-low), ena (global hold), pins (TT pin bundle):
//        ui_in operand, uio_in load_a/load_b/start, uo_out result, uio_out flags.
module tt_um_serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   serial_sub_if.slave  pins
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_hold, b_hold;
   logic [WIDTH-1:0]   a_sr, b_sr, r_sr, r_next;
   logic [2:0]         cnt;
   logic               a_msb, b_msb;
   logic [7:0]         uo_q;
   logic               borrow_q, ovf_q;
   logic               start, start_acc, in_shift, last;
   logic               d, br_next;
   logic [7:0]         res8;

   assign start     = pins.uio_in[UIO_START];
   assign in_shift  = (state_q == SHIFT);
   assign start_acc = start && !in_shift;
   assign last      = in_shift && (cnt == 3'(WIDTH-1));
   assign r_next    = {d, r_sr[WIDTH-1:1]};

   // Upper ui_in bits (when WIDTH < 8) and uio_in[7:3] are don't-care inputs.
   logic unused_pins;
   assign unused_pins = &{1'b0, pins.ui_in, pins.uio_in};

   always_comb begin
      res8 = '0;
      res8[WIDTH-1:0] = r_next;
   end

   serial_sub_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .clr     (start_acc),
      .shift   (in_shift),
      .a0      (a_sr[0]),
      .b0      (b_sr[0]),
      .d       (d),
      .br_next (br_next)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else if (ena)
         state_q <= state_d;
   end

   // FSM next state; start in SHIFT is ignored
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = SHIFT;
         SHIFT:      if (last)  state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Operand, shift and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_hold   <= '0;
         b_hold   <= '0;
         a_sr     <= '0;
         b_sr     <= '0;
         r_sr     <= '0;
         cnt      <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         uo_q     <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (ena) begin
         if (pins.uio_in[UIO_LOAD_A]) a_hold <= pins.ui_in[WIDTH-1:0];
         if (pins.uio_in[UIO_LOAD_B]) b_hold <= pins.ui_in[WIDTH-1:0];
         if (start_acc) begin
            // pre-edge hold values: a load in the same cycle waits for next run
            a_sr  <= a_hold;
            b_sr  <= b_hold;
            a_msb <= a_hold[WIDTH-1];
            b_msb <= b_hold[WIDTH-1];
            cnt   <= '0;
         end else if (in_shift) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_next;
            cnt  <= cnt + 3'd1;
            if (last) begin
               uo_q     <= res8;
               borrow_q <= br_next;
               // signed overflow: operand signs differ and result sign left A's
               ovf_q    <= (a_msb != b_msb) && (d != a_msb);
            end
         end
      end
   end

   assign pins.uo_out  = uo_q;
   assign pins.uio_out = {ovf_q, borrow_q, (state_q == DONE), in_shift, 4'b0000};
   assign pins.uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
module tb_tt_um_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   serial_sub_if pins ();

   tt_um_serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .pins  (pins)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance n rising edges, land 1ns after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] data, input logic [7:0] ctl);
      pins.ui_in  = data;
      pins.uio_in = ctl;
      tick(1);
      pins.uio_in = 8'h00;
   endtask

   task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
      pulse(a, 8'h01);
      pulse(b, 8'h02);
   endtask

   task automatic chk_flags(input string tag, input logic busy, input logic done);
      chk({tag, ".busy"}, 32'(pins.uio_out[4]), 32'(busy));
      chk({tag, ".done"}, 32'(pins.uio_out[5]), 32'(done));
   endtask

   task automatic chk_res(input string tag, input logic [7:0] r, input logic brw, input logic ovf);
      chk({tag, ".r"},      32'(pins.uo_out),     32'(r));
      chk({tag, ".borrow"}, 32'(pins.uio_out[6]), 32'(brw));
      chk({tag, ".ovf"},    32'(pins.uio_out[7]), 32'(ovf));
      chk({tag, ".lo"},     32'(pins.uio_out[3:0]), 32'h0);
   endtask

   // full run from already-loaded operands; prev_r is the result still shown
   task automatic run_op(input string tag, input logic [7:0] prev_r,
                         input logic [7:0] r, input logic brw, input logic ovf);
      pulse(8'h00, 8'h04);
      chk_flags({tag, ".k"}, 1'b1, 1'b0);
      tick(7);
      chk_flags({tag, ".k7"}, 1'b1, 1'b0);
      chk({tag, ".hold"}, 32'(pins.uo_out), 32'(prev_r));
      tick(1);
      chk_flags({tag, ".k8"}, 1'b0, 1'b1);
      chk_res(tag, r, brw, ovf);
   endtask

   initial begin
      pins.ui_in  = 8'h00;
      pins.uio_in = 8'h00;
      #12;
      chk_res("rst", 8'h00, 1'b0, 1'b0);
      chk_flags("rst", 1'b0, 1'b0);
      chk("rst.oe", 32'(pins.uio_oe), 32'hF0);
      rst_n = 1'b1;
      tick(1);

      // basic arithmetic
      load_ab(8'h50, 8'h20);
      run_op("sub1", 8'h00, 8'h30, 1'b0, 1'b0);
      tick(2);
      chk_flags("sticky", 1'b0, 1'b1);
      load_ab(8'h20, 8'h50);
      run_op("sub2", 8'h30, 8'hD0, 1'b1, 1'b0);
      load_ab(8'h80, 8'h01);
      run_op("sub3", 8'hD0, 8'h7F, 1'b0, 1'b1);

      // start and load_a mid-SHIFT: 0x30-0x10, then next run uses A=0xFF
      load_ab(8'h30, 8'h10);
      pulse(8'h00, 8'h04);            // edge k
      tick(2);                        // k+2
      pulse(8'h00, 8'h04);            // k+3, ignored
      pulse(8'hFF, 8'h01);            // k+4, next op only
      tick(3);                        // k+7
      chk_flags("mid.k7", 1'b1, 1'b0);
      tick(1);                        // k+8
      chk_flags("mid.k8", 1'b0, 1'b1);
      chk_res("mid", 8'h20, 1'b0, 1'b0);
      run_op("aff", 8'h20, 8'hEF, 1'b0, 1'b0);

      // same-cycle load_a with start uses the old A
      load_ab(8'h05, 8'h01);
      pins.ui_in  = 8'h10;
      pins.uio_in = 8'h05;
      tick(1);
      pins.uio_in = 8'h00;
      chk_flags("same.k", 1'b1, 1'b0);
      tick(8);
      chk_flags("same.k8", 1'b0, 1'b1);
      chk_res("same", 8'h04, 1'b0, 1'b0);
      run_op("newa", 8'h04, 8'h0F, 1'b0, 1'b0);

      // ena low for 3 cycles mid-SHIFT; load/start while frozen are ignored
      load_ab(8'h03, 8'h05);
      pulse(8'h00, 8'h04);            // edge k
      tick(2);
      ena = 1'b0;
      pins.ui_in  = 8'h77;
      pins.uio_in = 8'h07;
      tick(3);
      chk_flags("ena.frz", 1'b1, 1'b0);
      pins.uio_in = 8'h00;
      ena = 1'b1;
      tick(5);
      chk_flags("ena.late", 1'b1, 1'b0);
      tick(1);
      chk_flags("ena.done", 1'b0, 1'b1);
      chk_res("ena", 8'hFE, 1'b1, 1'b0);
      run_op("ena.rerun", 8'hFE, 8'hFE, 1'b1, 1'b0);

      // async reset mid-SHIFT
      load_ab(8'h09, 8'h02);
      pulse(8'h00, 8'h04);
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_res("arst", 8'h00, 1'b0, 1'b0);
      chk_flags("arst", 1'b0, 1'b0);
      chk("arst.oe", 32'(pins.uio_oe), 32'hF0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      chk_flags("arst.idle", 1'b0, 1'b0);
      run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);

      // start held high: restart from DONE, one result per 9 cycles
      load_ab(8'h09, 8'h04);
      pins.uio_in = 8'h04;
      tick(1);                        // k
      chk_flags("b2b.k", 1'b1, 1'b0);
      pins.ui_in  = 8'h02;
      pins.uio_in = 8'h06;            // load B=2 for the next run
      tick(1);                        // k+1
      pins.uio_in = 8'h04;
      tick(6);                        // k+7
      chk_flags("b2b.k7", 1'b1, 1'b0);
      tick(1);                        // k+8
      chk_flags("b2b.d1", 1'b0, 1'b1);
      chk_res("b2b1", 8'h05, 1'b0, 1'b0);
      tick(1);                        // k+9
      chk_flags("b2b.re", 1'b1, 1'b0);
      chk("b2b.hold", 32'(pins.uo_out), 32'h05);
      tick(8);                        // k+17
      chk_flags("b2b.d2", 1'b0, 1'b1);
      chk_res("b2b2", 8'h07, 1'b0, 1'b0);
      pins.uio_in = 8'h00;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
